// File: rtl/rancnet_pkg.sv
// rancnet_pkg: shared definitions for the RANC network AXIS ingress path.
//   - Spike packet field widths and bit positions (DX | DY | axon | tick).
//   - ptr_w(): width of a wrap-bit circular-buffer pointer for a given depth.
//   - err_idx_e: bit positions of the sticky error flags in the status vector.
package rancnet_pkg;

    localparam int unsigned DX_WIDTH     = 9;
    localparam int unsigned DY_WIDTH     = 9;
    localparam int unsigned AXON_WIDTH   = 8;
    localparam int unsigned TICK_WIDTH   = 4;
    localparam int unsigned PACKET_WIDTH = DX_WIDTH + DY_WIDTH + AXON_WIDTH + TICK_WIDTH;

    localparam int unsigned DX_MSB   = PACKET_WIDTH - 1;
    localparam int unsigned DX_LSB   = DX_MSB - DX_WIDTH + 1;
    localparam int unsigned DY_MSB   = DX_LSB - 1;
    localparam int unsigned DY_LSB   = DY_MSB - DY_WIDTH + 1;
    localparam int unsigned AXON_MSB = DY_LSB - 1;
    localparam int unsigned AXON_LSB = AXON_MSB - AXON_WIDTH + 1;
    localparam int unsigned TICK_MSB = AXON_LSB - 1;
    localparam int unsigned TICK_LSB = 0;

    // Pointer width with one extra MSB used as the wrap bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef enum logic [1:0] {
        ERR_STRB      = 2'd0,
        ERR_FRAME     = 2'd1,
        ERR_UNDERFLOW = 2'd2
    } err_idx_e;

    localparam int unsigned ERR_COUNT = 3;

endpackage

// File: rtl/tick_commit_fifo.sv
// tick_commit_fifo: circular packet store with separate write, commit and
// read pointers. Only entries between rd_ptr and cm_ptr are visible to the
// reader; the commit strobe publishes everything written before that cycle.
//   clk, rst_n  : clock, synchronous active-low reset
//   wr_en/wr_data : write one entry at wr_ptr (ignored while full)
//   commit      : tick-gated mode: cm_ptr <= wr_ptr (pre-cycle value)
//   rd_en       : pop committed entry into rd_data (1-cycle latency)
//   empty/full/count : committed-empty, physically-full, committed unread count
module tick_commit_fifo
    import rancnet_pkg::*;
#(
    parameter int unsigned DATA_W     = 30,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned TICK_GATED = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      commit,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      empty,
    output logic                      full,
    output logic [ptr_w(DEPTH)-1:0]   count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = ptr_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  cm_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              commit_now;
    logic              do_wr;
    logic              do_rd;

    // Streaming mode commits every cycle, so cm_ptr trails wr_ptr by one cycle.
    assign commit_now = (TICK_GATED != 0) ? commit : 1'b1;

    assign full  = (wr_ptr - rd_ptr) == PTR_W'(DEPTH);
    assign empty = (cm_ptr == rd_ptr);
    assign count = cm_ptr - rd_ptr;

    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            cm_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (commit_now) begin
                cm_ptr <= wr_ptr;
            end
            if (do_rd) begin
                rd_data <= mem[rd_ptr[AW-1:0]];
                rd_ptr  <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/axis_tick_ingress.sv
// axis_tick_ingress: AXIS slave feeding spike packets into a tick-committed
// store drained by the grid through read_en/empty.
//   s00_axis_aclk/aresetn : clock, synchronous active-low reset
//   tick                  : tick strobe; commits stored packets (tick-gated mode)
//   s00_axis_*            : AXIS slave (tvalid/tready/tdata/tstrb/tlast)
//   read_en, dout         : grid read port, dout valid one cycle after read_en
//   empty, full, committed_count : store status
//   tick_count            : beats accepted since last tick (quota counter)
//   strb_error, frame_error, underflow_error : sticky, cleared only by reset
module axis_tick_ingress #(
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned PACKET_WIDTH           = rancnet_pkg::PACKET_WIDTH,
    parameter int unsigned BUFFER_DEPTH           = 512,
    parameter int unsigned MAX_PACKETS_PER_TICK   = 200,
    parameter int unsigned TICK_GATED             = 1
) (
    input  logic                                    s00_axis_aclk,
    input  logic                                    s00_axis_aresetn,
    input  logic                                    tick,
    input  logic                                    s00_axis_tvalid,
    output logic                                    s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]       s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]     s00_axis_tstrb,
    input  logic                                    s00_axis_tlast,
    input  logic                                    read_en,
    output logic [PACKET_WIDTH-1:0]                 dout,
    output logic                                    empty,
    output logic                                    full,
    output logic [$clog2(BUFFER_DEPTH):0]           committed_count,
    output logic [$clog2(MAX_PACKETS_PER_TICK):0]   tick_count,
    output logic                                    strb_error,
    output logic                                    frame_error,
    output logic                                    underflow_error
);

    import rancnet_pkg::*;

    localparam int unsigned TC_W      = $clog2(MAX_PACKETS_PER_TICK) + 1;
    localparam int unsigned PKT_BYTES = (PACKET_WIDTH + 7) / 8;
    localparam logic [TC_W-1:0] QUOTA = TC_W'(MAX_PACKETS_PER_TICK);

    logic [TC_W-1:0]      tick_cnt_q;
    logic                 open_burst_q;
    logic [ERR_COUNT-1:0] err_q;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 accept;
    logic                 strb_ok;
    logic                 wr_en;
    logic                 unused_ok;

    assign s00_axis_tready = s00_axis_aresetn & ~fifo_full & (tick_cnt_q < QUOTA);
    assign accept          = s00_axis_tvalid & s00_axis_tready;

    // Only the strobes covering the packet bytes matter; padding bytes are don't-care.
    assign strb_ok = &s00_axis_tstrb[PKT_BYTES-1:0];
    assign wr_en   = accept & strb_ok;

    assign unused_ok = ^{s00_axis_tdata, s00_axis_tstrb};

    tick_commit_fifo #(
        .DATA_W     (PACKET_WIDTH),
        .DEPTH      (BUFFER_DEPTH),
        .TICK_GATED (TICK_GATED)
    ) u_store (
        .clk     (s00_axis_aclk),
        .rst_n   (s00_axis_aresetn),
        .wr_en   (wr_en),
        .wr_data (s00_axis_tdata[PACKET_WIDTH-1:0]),
        .commit  (tick),
        .rd_en   (read_en),
        .rd_data (dout),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (committed_count)
    );

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            tick_cnt_q   <= '0;
            open_burst_q <= 1'b0;
            err_q        <= '0;
        end else begin
            if (accept && !strb_ok) begin
                err_q[ERR_STRB] <= 1'b1;
            end
            if (read_en && fifo_empty) begin
                err_q[ERR_UNDERFLOW] <= 1'b1;
            end
            if (tick) begin
                if (open_burst_q) begin
                    err_q[ERR_FRAME] <= 1'b1;
                end
                // A beat accepted in the tick cycle starts the new tick's burst.
                tick_cnt_q   <= accept ? TC_W'(1) : '0;
                open_burst_q <= accept & ~s00_axis_tlast;
            end else if (accept) begin
                // tready is low at the quota, so this increment saturates there.
                tick_cnt_q   <= tick_cnt_q + TC_W'(1);
                open_burst_q <= ~s00_axis_tlast;
            end
        end
    end

    assign empty           = fifo_empty;
    assign full            = fifo_full;
    assign tick_count      = tick_cnt_q;
    assign strb_error      = err_q[ERR_STRB];
    assign frame_error     = err_q[ERR_FRAME];
    assign underflow_error = err_q[ERR_UNDERFLOW];

endmodule

// File: tb/tb_axis_tick_ingress.sv
module tb_axis_tick_ingress;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Tick-gated instance (g_*) and streaming instance (s_*), both DEPTH=8, quota=4.
    logic        g_rstn, g_tick, g_tvalid, g_tlast, g_read;
    logic [31:0] g_tdata;
    logic [3:0]  g_tstrb;
    logic        g_tready, g_empty, g_full, g_serr, g_ferr, g_uerr;
    logic [29:0] g_dout;
    logic [3:0]  g_cnt;
    logic [2:0]  g_tc;

    logic        s_rstn, s_tick, s_tvalid, s_tlast, s_read;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb;
    logic        s_tready, s_empty, s_full, s_serr, s_ferr, s_uerr;
    logic [29:0] s_dout;
    logic [3:0]  s_cnt;
    logic [2:0]  s_tc;

    axis_tick_ingress #(
        .C_S00_AXIS_TDATA_WIDTH (32),
        .PACKET_WIDTH           (30),
        .BUFFER_DEPTH           (8),
        .MAX_PACKETS_PER_TICK   (4),
        .TICK_GATED             (1)
    ) dut_g (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (g_rstn),
        .tick             (g_tick),
        .s00_axis_tvalid  (g_tvalid),
        .s00_axis_tready  (g_tready),
        .s00_axis_tdata   (g_tdata),
        .s00_axis_tstrb   (g_tstrb),
        .s00_axis_tlast   (g_tlast),
        .read_en          (g_read),
        .dout             (g_dout),
        .empty            (g_empty),
        .full             (g_full),
        .committed_count  (g_cnt),
        .tick_count       (g_tc),
        .strb_error       (g_serr),
        .frame_error      (g_ferr),
        .underflow_error  (g_uerr)
    );

    axis_tick_ingress #(
        .C_S00_AXIS_TDATA_WIDTH (32),
        .PACKET_WIDTH           (30),
        .BUFFER_DEPTH           (8),
        .MAX_PACKETS_PER_TICK   (4),
        .TICK_GATED             (0)
    ) dut_s (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (s_rstn),
        .tick             (s_tick),
        .s00_axis_tvalid  (s_tvalid),
        .s00_axis_tready  (s_tready),
        .s00_axis_tdata   (s_tdata),
        .s00_axis_tstrb   (s_tstrb),
        .s00_axis_tlast   (s_tlast),
        .read_en          (s_read),
        .dout             (s_dout),
        .empty            (s_empty),
        .full             (s_full),
        .committed_count  (s_cnt),
        .tick_count       (s_tc),
        .strb_error       (s_serr),
        .frame_error      (s_ferr),
        .underflow_error  (s_uerr)
    );

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
        logic        t;
        logic        r;
        logic        e_rdy;
        logic        e_empty;
        logic        e_full;
        logic [3:0]  e_cnt;
        logic [2:0]  e_tc;
        logic [29:0] e_dout;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [31:0] d, input logic [3:0] s,
                                input logic l, input logic t, input logic r,
                                input logic e_rdy, input logic e_empty, input logic e_full,
                                input logic [3:0] e_cnt, input logic [2:0] e_tc,
                                input logic [29:0] e_dout);
        vec_t x;
        x.v = v; x.d = d; x.s = s; x.l = l; x.t = t; x.r = r;
        x.e_rdy = e_rdy; x.e_empty = e_empty; x.e_full = e_full;
        x.e_cnt = e_cnt; x.e_tc = e_tc; x.e_dout = e_dout;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle on the tick-gated instance; outputs are sampled 1 time unit after the edge.
    task automatic g_cyc(input logic v, input logic [31:0] d, input logic [3:0] s,
                         input logic l, input logic t, input logic r);
        g_tvalid = v; g_tdata = d; g_tstrb = s; g_tlast = l; g_tick = t; g_read = r;
        @(posedge clk); #1;
        g_tvalid = 1'b0; g_tick = 1'b0; g_read = 1'b0;
    endtask

    task automatic s_cyc(input logic v, input logic [31:0] d, input logic [3:0] s,
                         input logic l, input logic t, input logic r);
        s_tvalid = v; s_tdata = d; s_tstrb = s; s_tlast = l; s_tick = t; s_read = r;
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tick = 1'b0; s_read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [29:0] exp_q[$];
        g_rstn = 1'b0; g_tick = 1'b0; g_tvalid = 1'b0; g_tlast = 1'b0; g_read = 1'b0;
        g_tdata = '0; g_tstrb = '0;
        s_rstn = 1'b0; s_tick = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_read = 1'b0;
        s_tdata = '0; s_tstrb = '0;

        // Test 1 (reads of 1,2,3), test 2 (quota) and test 4 (tick-cycle write).
        tbl.push_back(mk(1, 32'h1, 4'hF, 0, 0, 0, 1, 1, 0, 0, 1, 30'h0));
        tbl.push_back(mk(1, 32'h2, 4'hF, 0, 0, 0, 1, 1, 0, 0, 2, 30'h0));
        tbl.push_back(mk(1, 32'h3, 4'hF, 1, 0, 0, 1, 1, 0, 0, 3, 30'h0));
        tbl.push_back(mk(0, 32'h0, 4'hF, 0, 0, 0, 1, 1, 0, 0, 3, 30'h0));
        tbl.push_back(mk(0, 32'h0, 4'hF, 0, 1, 0, 1, 0, 0, 3, 0, 30'h0));
        tbl.push_back(mk(0, 32'h0, 4'hF, 0, 0, 1, 1, 0, 0, 2, 0, 30'h1));
        tbl.push_back(mk(0, 32'h0, 4'hF, 0, 0, 1, 1, 0, 0, 1, 0, 30'h2));
        tbl.push_back(mk(0, 32'h0, 4'hF, 0, 0, 1, 1, 1, 0, 0, 0, 30'h3));
        tbl.push_back(mk(0, 32'h0, 4'hF, 0, 0, 0, 1, 1, 0, 0, 0, 30'h3));
        tbl.push_back(mk(1, 32'h11, 4'hF, 1, 0, 0, 1, 1, 0, 0, 1, 30'h3));
        tbl.push_back(mk(1, 32'h12, 4'hF, 1, 0, 0, 1, 1, 0, 0, 2, 30'h3));
        tbl.push_back(mk(1, 32'h13, 4'hF, 1, 0, 0, 1, 1, 0, 0, 3, 30'h3));
        tbl.push_back(mk(1, 32'h14, 4'hF, 1, 0, 0, 0, 1, 0, 0, 4, 30'h3));
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(1, 32'h15 + 32'(i), 4'hF, 1, 0, 0, 0, 1, 0, 0, 4, 30'h3));
        tbl.push_back(mk(0, 32'h0, 4'hF, 0, 1, 0, 1, 0, 0, 4, 0, 30'h3));
        tbl.push_back(mk(1, 32'hA, 4'hF, 1, 1, 0, 1, 0, 0, 4, 1, 30'h3));
        tbl.push_back(mk(0, 32'h0, 4'hF, 0, 1, 0, 1, 0, 0, 5, 0, 30'h3));
        tbl.push_back(mk(0, 32'h0, 4'hF, 0, 0, 1, 1, 0, 0, 4, 0, 30'h11));
        tbl.push_back(mk(0, 32'h0, 4'hF, 0, 0, 1, 1, 0, 0, 3, 0, 30'h12));
        tbl.push_back(mk(0, 32'h0, 4'hF, 0, 0, 1, 1, 0, 0, 2, 0, 30'h13));
        tbl.push_back(mk(0, 32'h0, 4'hF, 0, 0, 1, 1, 0, 0, 1, 0, 30'h14));
        tbl.push_back(mk(0, 32'h0, 4'hF, 0, 0, 1, 1, 1, 0, 0, 0, 30'hA));

        repeat (3) @(posedge clk);
        #1;
        chk("rst.g_tready", g_tready, 0);
        chk("rst.g_empty", g_empty, 1);
        chk("rst.g_full", g_full, 0);
        chk("rst.g_dout", g_dout, 0);
        chk("rst.g_cnt", g_cnt, 0);
        chk("rst.g_tc", g_tc, 0);
        chk("rst.g_flags", {g_serr, g_ferr, g_uerr}, 0);
        chk("rst.s_tready", s_tready, 0);
        chk("rst.s_empty", s_empty, 1);
        g_rstn = 1'b1;
        s_rstn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            g_cyc(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].l, tbl[i].t, tbl[i].r);
            chk($sformatf("v%0d.tready", i), g_tready, tbl[i].e_rdy);
            chk($sformatf("v%0d.empty", i), g_empty, tbl[i].e_empty);
            chk($sformatf("v%0d.full", i), g_full, tbl[i].e_full);
            chk($sformatf("v%0d.count", i), g_cnt, tbl[i].e_cnt);
            chk($sformatf("v%0d.tick_count", i), g_tc, tbl[i].e_tc);
            chk($sformatf("v%0d.dout", i), g_dout, tbl[i].e_dout);
        end

        // Test 3: full and pointer wrap. Reset is held with tick/write/read all active.
        g_rstn = 1'b0;
        g_cyc(1, 32'h77, 4'hF, 1, 1, 1);
        chk("wrap.rst_cnt", g_cnt, 0);
        chk("wrap.rst_tc", g_tc, 0);
        g_rstn = 1'b1;
        for (int i = 0; i < 4; i++) g_cyc(1, 32'h20 + 32'(i), 4'hF, 1, 0, 0);
        g_cyc(0, 0, 4'hF, 0, 1, 0);
        for (int i = 4; i < 8; i++) g_cyc(1, 32'h20 + 32'(i), 4'hF, 1, 0, 0);
        chk("wrap.full8", g_full, 1);
        g_cyc(0, 0, 4'hF, 0, 1, 0);
        chk("wrap.cnt8", g_cnt, 8);
        chk("wrap.tready_full", g_tready, 0);
        g_cyc(1, 32'h99, 4'hF, 1, 0, 0);
        chk("wrap.stall_tc", g_tc, 0);
        for (int i = 0; i < 5; i++) begin
            g_cyc(0, 0, 4'hF, 0, 0, 1);
            chk($sformatf("wrap.rd%0d", i), g_dout, 32'h20 + 32'(i));
        end
        chk("wrap.tready_resume", g_tready, 1);
        for (int i = 0; i < 4; i++) g_cyc(1, 32'h28 + 32'(i), 4'hF, 1, 0, 0);
        chk("wrap.full7", g_full, 0);
        chk("wrap.quota_rdy", g_tready, 0);
        g_cyc(0, 0, 4'hF, 0, 1, 0);
        g_cyc(1, 32'h2C, 4'hF, 1, 0, 0);
        chk("wrap.full_again", g_full, 1);
        chk("wrap.tready_refull", g_tready, 0);
        g_cyc(0, 0, 4'hF, 0, 1, 0);
        chk("wrap.cnt_wrapped", g_cnt, 8);
        for (int i = 5; i < 13; i++) exp_q.push_back(30'h20 + 30'(i));
        for (int i = 0; i < 8; i++) begin
            g_cyc(0, 0, 4'hF, 0, 0, 1);
            chk($sformatf("wrap.rd_b%0d", i), g_dout, exp_q.pop_front());
        end
        chk("wrap.empty_end", g_empty, 1);

        // Test 5: sticky errors.
        g_cyc(1, 32'h33, 4'b0111, 1, 0, 0);
        chk("err.strb", g_serr, 1);
        chk("err.strb_tc", g_tc, 1);
        g_cyc(0, 0, 4'hF, 0, 1, 0);
        chk("err.strb_notstored", g_cnt, 0);
        g_cyc(1, 32'h44, 4'hF, 0, 0, 0);
        chk("err.frame_pre", g_ferr, 0);
        g_cyc(0, 0, 4'hF, 0, 1, 0);
        chk("err.frame", g_ferr, 1);
        chk("err.frame_cnt", g_cnt, 1);
        g_cyc(0, 0, 4'hF, 0, 0, 1);
        chk("err.read44", g_dout, 32'h44);
        chk("err.uflow_pre", g_uerr, 0);
        g_cyc(0, 0, 4'hF, 0, 0, 1);
        chk("err.uflow", g_uerr, 1);
        chk("err.dout_hold", g_dout, 32'h44);
        repeat (3) g_cyc(0, 0, 4'hF, 1, 1, 0);
        chk("err.sticky", {g_serr, g_ferr, g_uerr}, 3'b111);
        g_rstn = 1'b0;
        g_cyc(0, 0, 4'hF, 0, 0, 0);
        g_rstn = 1'b1;
        chk("err.cleared", {g_serr, g_ferr, g_uerr}, 3'b000);

        // Test 6: streaming mode and reset mid-burst.
        s_cyc(1, 32'h5, 4'hF, 1, 0, 0);
        chk("strm.empty_accept", s_empty, 1);
        s_cyc(0, 0, 4'hF, 0, 0, 0);
        chk("strm.empty_next", s_empty, 0);
        chk("strm.cnt", s_cnt, 1);
        s_cyc(0, 0, 4'hF, 0, 0, 1);
        chk("strm.dout", s_dout, 32'h5);
        s_cyc(0, 0, 4'hF, 0, 0, 1);
        chk("strm.uflow", s_uerr, 1);
        s_cyc(1, 32'h6, 4'hF, 0, 0, 0);
        s_cyc(1, 32'h7, 4'hF, 0, 0, 0);
        chk("strm.tc2", s_tc, 3);
        s_rstn = 1'b0;
        s_cyc(1, 32'h8, 4'hF, 0, 1, 1);
        chk("strm.rst_tready", s_tready, 0);
        chk("strm.rst_cnt", s_cnt, 0);
        chk("strm.rst_empty", s_empty, 1);
        chk("strm.rst_tc", s_tc, 0);
        chk("strm.rst_dout", s_dout, 0);
        chk("strm.rst_flags", {s_serr, s_ferr, s_uerr}, 0);
        s_rstn = 1'b1;
        s_cyc(0, 0, 4'hF, 0, 0, 0);
        chk("strm.post_empty", s_empty, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
